// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: opcodes, ALUOp / write-back selects,
// trap causes, FSM state encoding and the control bundle that the decoder produces.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_ECALL   = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_1;
    logic       alu_src_2;
    logic       reg_write;
    logic [1:0] reg_write_sel;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/rv_main_decoder.sv
// Combinational opcode -> control bundle decoder, shared with the single-cycle core.
// Unknown opcodes yield an all-zero bundle with legal=0; SYSTEM is flagged separately.
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       legal,
  output logic       is_system
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl      = CTRL_NONE;
    legal     = 1'b1;
    is_system = 1'b0;
    case (opcode)
      OPC_R: begin
        ctrl.alu_op    = ALUOP_RTYPE;
        ctrl.reg_write = 1'b1;
      end
      OPC_I: begin
        ctrl.alu_op    = ALUOP_ITYPE;
        ctrl.alu_src_2 = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_src_2     = 1'b1;
        ctrl.mem_read      = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_sel = SEL_MEM;
      end
      OPC_STORE: begin
        ctrl.alu_src_2 = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_op = ALUOP_BRANCH;
        ctrl.branch = 1'b1;
      end
      OPC_JAL: begin
        ctrl.jump          = 1'b1;
        ctrl.alu_src_1     = 1'b1;
        ctrl.alu_src_2     = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_sel = SEL_PC4;
      end
      OPC_JALR: begin
        ctrl.jump          = 1'b1;
        ctrl.alu_src_2     = 1'b1;
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_sel = SEL_PC4;
      end
      OPC_LUI: begin
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_sel = SEL_IMM;
      end
      OPC_AUIPC: begin
        ctrl.alu_src_1 = 1'b1;
        ctrl.alu_src_2 = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OPC_SYSTEM: is_system = 1'b1;
      default:    legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory
// port with req/ready, plus retire counting, halt on ebreak and traps with cause.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RET_CNT_W      = 32,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 sys_bit20,
  input  logic                 mem_ready,
  input  logic                 resume,
  output logic                 mem_req,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 Branch,
  output logic                 Jump,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 ALUSrc_1,
  output logic                 ALUSrc_2,
  output logic                 RegWrite,
  output logic [1:0]           RegWriteSel,
  output logic [1:0]           ALUOp,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic                 halted,
  output logic [RET_CNT_W-1:0] instret
);

  localparam int WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WAIT_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e            state, state_next;
  cause_e            cause, cause_next;
  ctrl_t             ctrl_q, dec_ctrl;
  logic              dec_legal, dec_system;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit, retire;

  rv_main_decoder u_dec (
    .opcode    (opcode),
    .ctrl      (dec_ctrl),
    .legal     (dec_legal),
    .is_system (dec_system)
  );

  // A late mem_ready on the limit cycle still completes the access.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ready &&
                       (wait_cnt == WAIT_W'(WAIT_LIMIT));

  // Fetch completion must strobe in the same cycle as mem_ready, so it is the
  // registered instruction request qualified by ready.
  assign ir_write    = mem_req && !i_or_d && mem_ready;
  assign pc_write    = ir_write;
  assign ALUOp       = ctrl_q.alu_op;
  assign ALUSrc_1    = ctrl_q.alu_src_1;
  assign ALUSrc_2    = ctrl_q.alu_src_2;
  assign RegWriteSel = ctrl_q.reg_write_sel;
  assign trap_cause  = cause;

  always_comb begin
    state_next = state;
    cause_next = cause;
    retire     = 1'b0;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (dec_system) begin
          if (!sys_bit20) begin
            state_next = S_TRAP;
            cause_next = CAUSE_ECALL;
          end else if (HALT_ON_EBREAK) begin
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl_q.mem_read || ctrl_q.mem_write) begin
          state_next = S_MEM;
        end else if (ctrl_q.reg_write) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_next = ctrl_q.mem_read ? S_WB : S_FETCH;
          retire     = !ctrl_q.mem_read;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  if (resume) state_next = S_FETCH;
      S_TRAP: begin
        if (resume) begin
          state_next = S_FETCH;
          cause_next = CAUSE_NONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free and
  // line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cause    <= CAUSE_NONE;
      ctrl_q   <= CTRL_NONE;
      wait_cnt <= '0;
      instret  <= '0;
      mem_req  <= 1'b0;
      i_or_d   <= 1'b0;
      Branch   <= 1'b0;
      Jump     <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      RegWrite <= 1'b0;
      trap     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      cause <= cause_next;
      if (state == S_DECODE) ctrl_q <= dec_ctrl;
      if (retire) instret <= instret + RET_CNT_W'(1);
      if (state_next != state)      wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      mem_req  <= (state_next == S_FETCH) || (state_next == S_MEM);
      i_or_d   <= (state_next == S_MEM);
      MemRead  <= (state_next == S_MEM) && ctrl_q.mem_read;
      MemWrite <= (state_next == S_MEM) && ctrl_q.mem_write;
      Branch   <= (state_next == S_EXEC) && dec_ctrl.branch;
      Jump     <= (state_next == S_EXEC) && dec_ctrl.jump;
      RegWrite <= (state_next == S_WB);
      trap     <= (state_next == S_TRAP);
      halted   <= (state_next == S_HALT);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: randomized instruction streams checked cycle by cycle against an
// instruction-level model of the phases each opcode must walk through.
module tb_multicycle_control_fsm;

  localparam int T_OUT = 4;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JUMP = 4, K_SYS = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [6:0] opcode;
  logic       sys_bit20, mem_ready, resume;

  logic       mem_req, i_or_d, ir_write, pc_write, Branch, Jump, MemRead, MemWrite;
  logic       ALUSrc_1, ALUSrc_2, RegWrite, trap, halted;
  logic [1:0] RegWriteSel, ALUOp, trap_cause;
  logic [2:0] instret;

  logic       n_mem_req, n_i_or_d, n_ir_write, n_pc_write, n_branch, n_jump, n_mem_read;
  logic       n_mem_write, n_src1, n_src2, n_reg_write, n_trap, n_halted;
  logic [1:0] n_sel, n_aluop, n_cause;
  logic [7:0] n_instret;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  typedef struct {
    int         kind;
    logic [5:0] bundle;
    bit         br;
    bit         jmp;
  } ref_t;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(T_OUT), .RET_CNT_W(3), .HALT_ON_EBREAK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .sys_bit20(sys_bit20), .mem_ready(mem_ready),
    .resume(resume), .mem_req(mem_req), .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .Branch(Branch), .Jump(Jump), .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc_1(ALUSrc_1),
    .ALUSrc_2(ALUSrc_2), .RegWrite(RegWrite), .RegWriteSel(RegWriteSel), .ALUOp(ALUOp),
    .trap(trap), .trap_cause(trap_cause), .halted(halted), .instret(instret)
  );

  multicycle_control_fsm #(.TIMEOUT_CYCLES(0), .RET_CNT_W(8), .HALT_ON_EBREAK(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode), .sys_bit20(sys_bit20), .mem_ready(mem_ready),
    .resume(resume), .mem_req(n_mem_req), .i_or_d(n_i_or_d), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .Branch(n_branch), .Jump(n_jump), .MemRead(n_mem_read),
    .MemWrite(n_mem_write), .ALUSrc_1(n_src1), .ALUSrc_2(n_src2), .RegWrite(n_reg_write),
    .RegWriteSel(n_sel), .ALUOp(n_aluop), .trap(n_trap), .trap_cause(n_cause),
    .halted(n_halted), .instret(n_instret)
  );

  // Instruction-level reference: what each opcode means, straight from the opcode table.
  function automatic ref_t ref_decode(input logic [6:0] opc);
    ref_t r;
    r.kind = K_ILL; r.bundle = '0; r.br = 1'b0; r.jmp = 1'b0;
    case (opc)
      7'b0110011: begin r.kind = K_ALU;   r.bundle = {2'b10, 1'b0, 1'b0, 2'b00}; end
      7'b0010011: begin r.kind = K_ALU;   r.bundle = {2'b11, 1'b0, 1'b1, 2'b00}; end
      7'b0000011: begin r.kind = K_LOAD;  r.bundle = {2'b00, 1'b0, 1'b1, 2'b01}; end
      7'b0100011: begin r.kind = K_STORE; r.bundle = {2'b00, 1'b0, 1'b1, 2'b00}; end
      7'b1100011: begin r.kind = K_BR;    r.bundle = {2'b01, 1'b0, 1'b0, 2'b00}; r.br = 1'b1; end
      7'b1101111: begin r.kind = K_JUMP;  r.bundle = {2'b00, 1'b1, 1'b1, 2'b10}; r.jmp = 1'b1; end
      7'b1100111: begin r.kind = K_JUMP;  r.bundle = {2'b00, 1'b0, 1'b1, 2'b10}; r.jmp = 1'b1; end
      7'b0110111: begin r.kind = K_ALU;   r.bundle = {2'b00, 1'b0, 1'b0, 2'b11}; end
      7'b0010111: begin r.kind = K_ALU;   r.bundle = {2'b00, 1'b1, 1'b1, 2'b00}; end
      7'b1110011: r.kind = K_SYS;
      default:    r.kind = K_ILL;
    endcase
    return r;
  endfunction

  function automatic logic [10:0] mk(input bit req, iod, fin, br, jmp, mr, mw, rw, tr, hl);
    return {req, iod, fin, fin, br, jmp, mr, mw, rw, tr, hl};
  endfunction

  function automatic logic [10:0] ob_strb();
    return {mem_req, i_or_d, ir_write, pc_write, Branch, Jump, MemRead, MemWrite, RegWrite,
            trap, halted};
  endfunction

  function automatic logic [5:0] ob_bndl();
    return {ALUOp, ALUSrc_1, ALUSrc_2, RegWriteSel};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    exp_ret = 0;
  endtask

  // Expects HALT or TRAP now; checks it, pulses resume and checks the clean exit.
  task automatic end_stop(input bit is_halt, input logic [1:0] cause, input bit ill);
    logic [10:0] e;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, !is_halt, is_halt);
    settle();
    checks++;
    if (ob_strb() !== e) begin
      errors++; $display("FAIL stop_strobes got %b want %b", ob_strb(), e);
    end
    checks++;
    if (trap_cause !== cause) begin
      errors++; $display("FAIL trap_cause got %0d want %0d", trap_cause, cause);
    end
    if (ill) begin
      checks++;
      if (ob_bndl() !== 6'b0) begin
        errors++; $display("FAIL illegal_bundle got %b want 000000", ob_bndl());
      end
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    settle();
    checks++;
    if (trap_cause !== 2'b00 || mem_req !== 1'b1 || trap !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL resume_exit got cause=%0d req=%b trap=%b halt=%b want 0 1 0 0",
                         trap_cause, mem_req, trap, halted);
    end
    checks++;
    if (instret !== 3'(exp_ret)) begin
      errors++; $display("FAIL resume_instret got %0d want %0d", instret, 3'(exp_ret));
    end
  endtask

  // Runs one instruction from a FETCH cycle; fwait/mwait >= T_OUT means ready never comes.
  task automatic do_instr(input logic [6:0] opc, input bit b20, input int fwait, input int mwait);
    ref_t        r;
    logic [10:0] e;
    bit          fin, is_ld, is_st;
    r = ref_decode(opc);
    is_ld = (r.kind == K_LOAD);
    is_st = (r.kind == K_STORE);
    opcode = opc; sys_bit20 = b20;
    for (int k = 0; k <= fwait && k < T_OUT; k++) begin
      fin = (k == fwait);
      mem_ready = fin;
      settle();
      e = mk(1, 0, fin, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (ob_strb() !== e) begin
        errors++; $display("FAIL fetch_cycle%0d got %b want %b", k, ob_strb(), e);
      end
      step();
    end
    mem_ready = 1'b0;
    if (fwait >= T_OUT) begin
      end_stop(1'b0, 2'b11, 1'b0);
      return;
    end
    resume = 1'($urandom_range(0, 1));
    settle();
    checks++;
    if (ob_strb() !== 11'b0) begin
      errors++; $display("FAIL decode_strobes got %b want 0", ob_strb());
    end
    step();
    resume = 1'b0;
    if (r.kind == K_ILL) begin
      end_stop(1'b0, 2'b01, 1'b1);
      return;
    end
    if (r.kind == K_SYS) begin
      end_stop(b20, b20 ? 2'b00 : 2'b10, 1'b0);
      return;
    end
    resume = 1'($urandom_range(0, 1));
    settle();
    e = mk(0, 0, 0, r.br, r.jmp, 0, 0, 0, 0, 0);
    checks++;
    if (ob_strb() !== e) begin
      errors++; $display("FAIL exec_strobes got %b want %b", ob_strb(), e);
    end
    checks++;
    if (ob_bndl() !== r.bundle) begin
      errors++; $display("FAIL exec_bundle op=%b got %b want %b", opc, ob_bndl(), r.bundle);
    end
    step();
    resume = 1'b0;
    if (is_ld || is_st) begin
      for (int k = 0; k <= mwait && k < T_OUT; k++) begin
        mem_ready = (k == mwait);
        settle();
        e = mk(1, 1, 0, 0, 0, is_ld, is_st, 0, 0, 0);
        checks++;
        if (ob_strb() !== e) begin
          errors++; $display("FAIL mem_cycle%0d got %b want %b", k, ob_strb(), e);
        end
        step();
      end
      mem_ready = 1'b0;
      if (mwait >= T_OUT) begin
        end_stop(1'b0, 2'b11, 1'b0);
        return;
      end
    end
    if (r.kind == K_ALU || r.kind == K_LOAD || r.kind == K_JUMP) begin
      settle();
      e = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (ob_strb() !== e) begin
        errors++; $display("FAIL wb_strobes got %b want %b", ob_strb(), e);
      end
      step();
    end
    exp_ret++;
    settle();
    checks++;
    if (instret !== 3'(exp_ret) || mem_req !== 1'b1) begin
      errors++; $display("FAIL retire got instret=%0d req=%b want %0d 1", instret, mem_req,
                         3'(exp_ret));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    step(); step();
    checks++;
    if (ob_strb() !== 11'b0 || ob_bndl() !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b %b want 0", ob_strb(), ob_bndl());
    end
    checks++;
    if (instret !== 3'd0 || trap_cause !== 2'b00) begin
      errors++; $display("FAIL reset_counters got %0d %0d want 0 0", instret, trap_cause);
    end
    rst_n = 1'b1;
    settle();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_req got %b want 0", mem_req);
    end
    step();
    exp_ret = 0;
    checks++;
    if (mem_req !== 1'b1 || i_or_d !== 1'b0 || instret !== 3'd0) begin
      errors++; $display("FAIL first_fetch got req=%b iod=%b ret=%0d want 1 0 0",
                         mem_req, i_or_d, instret);
    end
  endtask

  task automatic test_add();
    do_instr(7'b0110011, 1'b0, 0, 0);
  endtask

  task automatic test_load_delay();
    do_instr(7'b0000011, 1'b0, 0, 3);
  endtask

  task automatic test_branch_store();
    do_instr(7'b1100011, 1'b0, 1, 0);
    do_instr(7'b0100011, 1'b0, 0, 2);
  endtask

  task automatic test_trap();
    do_instr(7'b0000000, 1'b0, 0, 0);
    do_instr(7'b1110011, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    do_instr(7'b0110011, 1'b0, T_OUT, 0);
    do_instr(7'b0110011, 1'b0, T_OUT - 1, 0);
    do_instr(7'b0000011, 1'b0, 0, T_OUT);
    do_instr(7'b0100011, 1'b0, 0, T_OUT - 1);
  endtask

  task automatic test_halt_reset();
    do_instr(7'b1110011, 1'b1, 0, 0);
    opcode = 7'b0000011;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step(); step();
    settle();
    checks++;
    if (mem_req !== 1'b1 || i_or_d !== 1'b1 || MemRead !== 1'b1) begin
      errors++; $display("FAIL pre_reset_mem got %b want req/iod/read high", ob_strb());
    end
    rst_n = 1'b0;
    settle();
    checks++;
    if (ob_strb() !== 11'b0 || ob_bndl() !== 6'b0 || instret !== 3'd0 || trap_cause !== 2'b00) begin
      errors++; $display("FAIL async_reset got %b %b ret=%0d want all 0", ob_strb(), ob_bndl(),
                         instret);
    end
    step();
    rst_n = 1'b1;
    step();
    exp_ret = 0;
    checks++;
    if (mem_req !== 1'b1 || instret !== 3'd0) begin
      errors++; $display("FAIL post_reset_fetch got req=%b ret=%0d want 1 0", mem_req, instret);
    end
  endtask

  task automatic test_wrap();
    logic [6:0] legal_ops [9];
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    for (int i = 0; i < 9; i++)
      do_instr(legal_ops[$urandom_range(0, 8)], 1'b0, $urandom_range(0, 2), $urandom_range(0, 3));
    checks++;
    if (instret !== 3'd1) begin
      errors++; $display("FAIL instret_wrap got %0d want 1", instret);
    end
  endtask

  task automatic test_random();
    logic [6:0] legal_ops [9];
    int         pick;
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 13);
      if (pick <= 8)       do_instr(legal_ops[pick], 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (pick == 9)  do_instr(7'b1110011, 1'b0, $urandom_range(0, 3), 0);
      else if (pick == 10) do_instr(7'b1110011, 1'b1, $urandom_range(0, 3), 0);
      else if (pick == 11) do_instr(7'($urandom), 1'($urandom), $urandom_range(0, 3),
                                    $urandom_range(0, 3));
      else if (pick == 12) do_instr(legal_ops[$urandom_range(0, 8)], 1'b0, T_OUT, 0);
      else                 do_instr(7'b0000011, 1'b0, 0, T_OUT);
    end
  endtask

  task automatic test_ebreak_nop();
    bit bad;
    bad = 1'b0;
    rst_n = 1'b0; rst2_n = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    step();
    rst2_n = 1'b1;
    step();
    for (int i = 0; i < 70; i++) begin
      settle();
      if (n_trap !== 1'b0 || n_mem_req !== 1'b1) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL no_timeout got trap or dropped req want req held, no trap");
    end
    opcode = 7'b1110011; sys_bit20 = 1'b1; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    settle();
    checks++;
    if (n_instret !== 8'd1 || n_halted !== 1'b0 || n_mem_req !== 1'b1) begin
      errors++; $display("FAIL ebreak_nop got ret=%0d halt=%b req=%b want 1 0 1",
                         n_instret, n_halted, n_mem_req);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    opcode = '0; sys_bit20 = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    test_reset();
    test_add();
    test_load_delay();
    test_branch_store();
    test_trap();
    test_timeout();
    test_halt_reset();
    test_wrap();
    test_random();
    do_reset();
    test_random();
    test_ebreak_nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
